// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes and
// the datapath select codes driven into the ALU and PC muxes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_R_WB    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_EX_ADDI = 4'd8,
    S_ADDI_WB = 4'd9,
    S_BEQ     = 4'd10,
    S_JMP     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States whose exit completes an instruction and returns to fetch.
  function automatic logic retires(state_t s);
    return (s == S_R_WB) || (s == S_MEM_WB) || (s == S_MEM_WR) ||
           (s == S_ADDI_WB) || (s == S_BEQ) || (s == S_JMP);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// RAM wait down-counter shared by the fetch and load states. A wait state
// lasts MEM_WAIT+1 cycles: idle count (0) in its first cycle, then MEM_WAIT..1.
module mc_wait_timer #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic idle,
  output logic done
);

  localparam logic [2:0] WAIT_VAL = 3'(MEM_WAIT);

  logic [2:0] cnt_q;

  assign idle = (cnt_q == 3'd0);
  // With no wait configured the first cycle is already the last one.
  assign done = (WAIT_VAL == 3'd0) || (cnt_q == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= WAIT_VAL;
    end else if (en) begin
      cnt_q <= done ? 3'd0 : cnt_q - 3'd1;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and
// write-back, decoding all datapath controls from the current state.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_we,
  output logic        reg_we,
  output logic        iord,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  import mc_pkg::*;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [15:0] count_q;
  logic        wait_state, tmr_load, tmr_en, tmr_idle, tmr_done;
  logic        pc_we_raw, ir_we_raw, mem_we_raw, reg_we_raw;

  assign wait_state = (state_q == S_IF) || (state_q == S_MEM_RD);
  assign tmr_en     = run && wait_state;
  assign tmr_load   = tmr_en && tmr_idle && !tmr_done;

  mc_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .idle  (tmr_idle),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= 6'd0;
      count_q <= 16'd0;
    end else if (run) begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= op;
      if (retires(state_q)) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we_raw  = 1'b0;
    ir_we_raw  = 1'b0;
    mem_we_raw = 1'b0;
    reg_we_raw = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    case (state_q)
      S_IF: begin
        if (tmr_done) begin
          ir_we_raw = 1'b1;
          pc_we_raw = 1'b1;
          alu_src_b = SRCB_FOUR;
          state_d   = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = SRCB_IMM;
        case (op)
          OP_R:         state_d = S_EX_R;
          OP_LW, OP_SW: state_d = S_EX_ADDR;
          OP_ADDI:      state_d = S_EX_ADDI;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_we_raw = 1'b1;
        reg_dst    = 1'b1;
        state_d    = S_IF;
      end
      S_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord = 1'b1;
        if (tmr_done) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we_raw = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_IF;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_we_raw = 1'b1;
        state_d    = S_IF;
      end
      S_EX_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_we_raw = 1'b1;
        state_d    = S_IF;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_BRANCH;
        pc_we_raw = zero;
        state_d   = S_IF;
      end
      S_JMP: begin
        pc_we_raw = 1'b1;
        pc_src    = PC_JUMP;
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // A frozen FSM must not repeat a write on every stalled cycle.
  assign pc_we       = run && pc_we_raw;
  assign ir_we       = run && ir_we_raw;
  assign mem_we      = run && mem_we_raw;
  assign reg_we      = run && reg_we_raw;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: a per-instruction table plus
// hand-written reset, freeze, halt and counter-wrap sequences.
module tb_multi_cycle_ctrl;

  import mc_pkg::*;

  localparam int unsigned MEM_WAIT = 1;
  localparam int W = 19;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } out_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       z;
    int         fz_idx;
    int         fz_len;
    int         cycles;
    int         reg_p;
    int         mem_p;
    int         pc_p;
    logic       retires;
  } row_t;

  logic        clk, rst_n, run, zero;
  logic [5:0]  op;
  logic        pc_we, ir_we, mem_we, reg_we, iord, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  multi_cycle_ctrl #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .op          (op),
    .zero        (zero),
    .pc_we       (pc_we),
    .ir_we       (ir_we),
    .mem_we      (mem_we),
    .reg_we      (reg_we),
    .iord        (iord),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t act;
  assign act = {state, pc_we, ir_we, mem_we, reg_we, iord, mem_to_reg, reg_dst,
                alu_src_a, alu_src_b, alu_op, pc_src, halted};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp, n_bad;
  int cyc, reg_p, mem_p, pc_p;
  logic [15:0] model_count;
  row_t rows[9];
  row_t halt_row, jmp_row, r_row;

  function automatic out_t blank(state_t st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push_instr(input logic [5:0] o_op, input logic z);
    out_t v;
    for (int i = 0; i < int'(MEM_WAIT); i++) exp_q.push_back(blank(S_IF));
    v = blank(S_IF); v.ir_we = 1'b1; v.pc_we = 1'b1; v.alu_src_b = 2'b01;
    exp_q.push_back(v);
    v = blank(S_ID); v.alu_src_b = 2'b10;
    exp_q.push_back(v);
    case (o_op)
      6'b000000: begin
        v = blank(S_EX_R); v.alu_src_a = 1'b1; v.alu_op = 2'b10; exp_q.push_back(v);
        v = blank(S_R_WB); v.reg_we = 1'b1; v.reg_dst = 1'b1; exp_q.push_back(v);
      end
      6'b100011: begin
        v = blank(S_EX_ADDR); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; exp_q.push_back(v);
        v = blank(S_MEM_RD); v.iord = 1'b1;
        for (int i = 0; i <= int'(MEM_WAIT); i++) exp_q.push_back(v);
        v = blank(S_MEM_WB); v.reg_we = 1'b1; v.mem_to_reg = 1'b1; exp_q.push_back(v);
      end
      6'b101011: begin
        v = blank(S_EX_ADDR); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; exp_q.push_back(v);
        v = blank(S_MEM_WR); v.iord = 1'b1; v.mem_we = 1'b1; exp_q.push_back(v);
      end
      6'b001000: begin
        v = blank(S_EX_ADDI); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; exp_q.push_back(v);
        v = blank(S_ADDI_WB); v.reg_we = 1'b1; exp_q.push_back(v);
      end
      6'b000100: begin
        v = blank(S_BEQ); v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01;
        v.pc_we = z; exp_q.push_back(v);
      end
      6'b000010: begin
        v = blank(S_JMP); v.pc_we = 1'b1; v.pc_src = 2'b10; exp_q.push_back(v);
      end
      default: begin
        v = blank(S_HALT); v.halted = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(v);
      end
    endcase
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic compare_front(input string name);
    out_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry, got %h", name, act);
    end else begin
      e = out_t'(exp_q.pop_front());
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s cyc %0d: outputs got %h want %h", name, cyc, act, e);
      end
    end
  endtask

  // driver: called at posedge+1 with inputs already set for this cycle
  task automatic cycle_check(input string name);
    @(negedge clk);
    cyc++;
    compare_front(name);
    if (reg_we) reg_p++;
    if (mem_we) mem_p++;
    if (pc_we) pc_p++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input row_t r);
    out_t f;
    int total;
    exp_q.delete();
    push_instr(r.op, r.z);
    op = r.op;
    zero = r.z;
    cyc = 0; reg_p = 0; mem_p = 0; pc_p = 0;
    total = exp_q.size();
    for (int i = 0; i < total; i++) begin
      if (i == r.fz_idx) begin
        f = out_t'(exp_q[0]);
        f.pc_we = 1'b0; f.ir_we = 1'b0; f.mem_we = 1'b0; f.reg_we = 1'b0;
        for (int k = 0; k < r.fz_len; k++) begin
          exp_q.push_front(f);
          run = 1'b0;
          cycle_check(r.name);
        end
        run = 1'b1;
      end
      cycle_check(r.name);
    end
    check_int({r.name, "_cycles"}, cyc, r.cycles);
    check_int({r.name, "_reg_we"}, reg_p, r.reg_p);
    check_int({r.name, "_mem_we"}, mem_p, r.mem_p);
    check_int({r.name, "_pc_we"}, pc_p, r.pc_p);
    if (r.retires) begin
      model_count = model_count + 16'd1;
      check_int({r.name, "_back_to_if"}, int'(state), int'(S_IF));
      check_int({r.name, "_count"}, int'(instr_count), int'(model_count));
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; model_count = 16'd0;
    cyc = 0; reg_p = 0; mem_p = 0; pc_p = 0;
    //         name         op          z    fz  len cyc reg mem pc  retires
    rows[0] = '{"r_type",   6'b000000, 1'b0, -1, 0, 5,  1,  0,  1, 1'b1};
    rows[1] = '{"lw",       6'b100011, 1'b0, -1, 0, 7,  1,  0,  1, 1'b1};
    rows[2] = '{"sw",       6'b101011, 1'b0, -1, 0, 5,  0,  1,  1, 1'b1};
    rows[3] = '{"addi",     6'b001000, 1'b0, -1, 0, 5,  1,  0,  1, 1'b1};
    rows[4] = '{"beq_taken",6'b000100, 1'b1, -1, 0, 4,  0,  0,  2, 1'b1};
    rows[5] = '{"beq_not",  6'b000100, 1'b0, -1, 0, 4,  0,  0,  1, 1'b1};
    rows[6] = '{"jmp",      6'b000010, 1'b0, -1, 0, 4,  0,  0,  2, 1'b1};
    rows[7] = '{"lw_freeze",6'b100011, 1'b0,  4, 3, 10, 1,  0,  1, 1'b1};
    rows[8] = '{"r_zero1",  6'b000000, 1'b1, -1, 0, 5,  1,  0,  1, 1'b1};
    halt_row = '{"halt",    6'b111111, 1'b0, -1, 0, 23, 0,  0,  1, 1'b0};
    jmp_row  = rows[6];
    r_row    = rows[0];

    rst_n = 1'b0; run = 1'b1; op = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(blank(S_IF));
    compare_front("reset_outputs");
    check_int("reset_count", int'(instr_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (rows[i]) run_row(rows[i]);

    // reset while EX_ADDI is active: ADDI_WB must never appear
    exp_q.delete();
    push_instr(6'b001000, 1'b0);
    op = 6'b001000; cyc = 0;
    for (int i = 0; i < 3; i++) cycle_check("addi_rst");
    @(negedge clk);
    compare_front("addi_rst_ex");
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_q.push_back(blank(S_IF));
    compare_front("addi_rst_abort");
    check_int("addi_rst_count", int'(instr_count), 0);
    model_count = 16'd0;
    reg_p = 0;
    repeat (3) begin
      @(negedge clk);
      if (reg_we) reg_p++;
    end
    check_int("addi_rst_no_reg_we", reg_p, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_row(r_row);

    // counter wrap: seed the count just below the wrap point, then retire one
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    model_count = 16'hFFFF;
    run_row(jmp_row);
    check_int("wrap_zero", int'(instr_count), 0);

    // illegal opcode halts until reset
    run_row(halt_row);
    check_int("halted_flag", int'(halted), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_q.push_back(blank(S_IF));
    compare_front("halt_reset_outputs");
    check_int("halt_reset_count", int'(instr_count), 0);
    model_count = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_row(jmp_row);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 1, is the number of extra cycles a synchronous RAM read needs before its data is valid; the legal range is 0..7.
REQ-002 Port clk, input, 1 bit: the single clock; every flop updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port run, input, 1 bit: when 1 the FSM advances; when 0 it freezes.
REQ-005 Port op, input, 6 bits: the opcode field of the instruction register.
REQ-006 Port zero, input, 1 bit: the ALU zero flag, valid in the BEQ state.
REQ-007 Outputs pc_we, ir_we, mem_we and reg_we, 1 bit each: write enables for the PC, the instruction register, data RAM and the register file.
REQ-008 Outputs iord, mem_to_reg, reg_dst and alu_src_a, 1 bit each: datapath mux selects.
REQ-009 Outputs alu_src_b, alu_op and pc_src, 2 bits each: ALU B select (00 reg, 01 const 4, 10 ex_imm), ALU operation class (00 add, 01 sub, 10 funct), and PC source (00 ALU, 01 branch target, 10 jump).
REQ-010 Output state, 4 bits: the current FSM state encoding.
REQ-011 Output halted, 1 bit: high while the FSM is in HALT.
REQ-012 Output instr_count, 16 bits: the count of retired instructions.

Function
REQ-013 The FSM SHALL have these states: IF, ID, EX_R, R_WB, EX_ADDR, MEM_RD, MEM_WB, MEM_WR, EX_ADDI, ADDI_WB, BEQ, JMP and HALT.
REQ-014 The FSM SHALL treat IF as a wait state: it occupies MEM_WAIT+1 cycles with iord=0; in the final cycle only, it asserts ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=01 and pc_src=00, and then moves to ID.
REQ-015 In ID, the FSM SHALL set alu_src_b=10 and alu_op=00, and branch on op:
- 000000 -> EX_R
- 100011 or 101011 -> EX_ADDR
- 001000 -> EX_ADDI
- 000100 -> BEQ
- 000010 -> JMP
- any other opcode -> HALT
REQ-016 EX_R SHALL assert alu_src_a=1, alu_src_b=00 and alu_op=10, then move to R_WB.
REQ-017 R_WB SHALL assert reg_we=1, reg_dst=1 and mem_to_reg=0, then move to IF.
REQ-018 EX_ADDR SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=00, then move to MEM_RD for op 100011 and to MEM_WR for op 101011; the FSM SHALL hold the op latched in ID for this decision.
REQ-019 MEM_RD SHALL occupy MEM_WAIT+1 cycles with iord=1 and then move to MEM_WB.
REQ-020 MEM_WB SHALL assert reg_we=1, reg_dst=0 and mem_to_reg=1, then move to IF.
REQ-021 MEM_WR SHALL assert iord=1 and mem_we=1 for exactly one cycle, then move to IF.
REQ-022 EX_ADDI SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=00, then move to ADDI_WB.
REQ-023 ADDI_WB SHALL assert reg_we=1, reg_dst=0 and mem_to_reg=0, then move to IF.
REQ-024 BEQ SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01 and pc_we=zero, then move to IF.
REQ-025 JMP SHALL assert pc_we=1 and pc_src=10, then move to IF.
REQ-026 HALT SHALL be sticky until reset, drive all write enables to 0 and hold halted=1.
REQ-027 instr_count SHALL increment by 1, wrapping from 16'hFFFF to 0, on each transition into IF from R_WB, MEM_WB, MEM_WR, ADDI_WB, BEQ or JMP.
REQ-028 When run=0, the FSM SHALL freeze the state, wait counter and instr_count, and force pc_we, ir_we, mem_we and reg_we to 0; when run returns to 1, execution SHALL resume in the same cycle of the same state.
REQ-029 Every output SHALL be decoded combinationally from state and the wait counter; no output depends combinationally on op except the ID next-state logic.
REQ-030 Any write enable not listed for a state SHALL be 0, and mux selects not listed SHALL be 0.

Reset
REQ-031 While rst_n=0, the block SHALL force state=IF, wait counter=0, instr_count=0 and halted=0, with all write enables 0.
REQ-032 A reset asserted mid-instruction SHALL abort it immediately, with no partial write issued after the asynchronous assertion.

Structure
REQ-033 Package mc_pkg SHALL hold the state encoding constants, the opcode constants (R, LW, SW, ADDI, BEQ, J) and the alu_op, alu_src_b and pc_src codes.
REQ-034 A single sub-module, mc_wait_timer, SHALL implement the MEM_WAIT down-counter with load, enable and done signals, and SHALL be shared by IF and MEM_RD.

Verification (MEM_WAIT=1, run=1)
REQ-035 R-type: op=000000 -> the instruction takes 5 cycles; ir_we pulses in cycle 2, reg_we=1 with reg_dst=1 in cycle 5, and instr_count goes 0->1.
REQ-036 lw then sw: op=100011 takes 7 cycles with mem_to_reg=1 in the last cycle; the following op=101011 takes 5 cycles with mem_we high for exactly 1 cycle; instr_count=2.
REQ-037 beq: zero=1 -> pc_we=1 with pc_src=01 in cycle 4; zero=0 -> pc_we=0 in BEQ; both cases take 4 cycles.
REQ-038 Illegal op=111111 -> ID goes to HALT, halted=1 and write enables stay 0 for 20 or more cycles; asserting rst_n=0 returns the FSM to IF with instr_count=0.
REQ-039 Freeze and reset: deasserting run in MEM_RD cycle 1 for 3 cycles stretches the lw to 10 cycles with no extra reg_we; asserting rst_n=0 during EX_ADDI means reg_we is never asserted.
REQ-040 Wrap: with instr_count preloaded to 16'hFFFF by running 65535 jumps, one more instruction makes instr_count=0.
